yz_event_counter: RTL and testbench

Downstream monitor for the y/z combinational decode stage. It registers the `y` and `z` outputs and detects rising edges on each. On a `start` command it counts those edges over a fixed window of `WIN_LEN` clock cycles, then presents both counts through a valid/ready report handshake. It turns the level outputs of the decode logic into per-window event statistics for the host side of the design.

---
 rtl/yz_mon_pkg.sv | 9 +
 rtl/yz_event_counter_rise_det.sv | 25 ++
 rtl/yz_event_counter.sv | 96 +++++++++
 tb/tb_yz_event_counter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yz_mon_pkg.sv
// Shared types and default constants for the y/z event monitor.
package yz_mon_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, REPORT} yz_state_t;

    localparam int YZ_CNT_W   = 8;
    localparam int YZ_WIN_LEN = 16;

endpackage

// File: rtl/yz_event_counter_rise_det.sv
// Two-register sample/history pair with a rising-edge detect on the registered value.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;
    logic p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
            p <= 1'b0;
        end else begin
            q <= d;
            p <= q;
        end
    end

    // Both terms are flops, so rise never depends combinationally on d.
    assign rise = q & ~p;

endmodule

// File: rtl/yz_event_counter.sv
// Counts y/z rising edges over a fixed window of WIN_LEN cycles after start,
// then offers both counts on a valid/ready report port.
module yz_event_counter
    import yz_mon_pkg::*;
#(
    parameter int CNT_W   = YZ_CNT_W,
    parameter int WIN_LEN = YZ_WIN_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] y_cnt,
    output logic [CNT_W-1:0] z_cnt,
    output yz_state_t        state
);

    localparam int               WIN_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             y_rise;
    logic             z_rise;
    logic [WIN_W-1:0] win;

    rise_det u_y_det (
        .clk  (clk),
        .rst  (rst),
        .d    (y),
        .rise (y_rise)
    );

    rise_det u_z_det (
        .clk  (clk),
        .rst  (rst),
        .d    (z),
        .rise (z_rise)
    );

    // Report handshake: rpt_valid is raised on entry to REPORT and only drops on
    // an edge where rpt_valid & rpt_ready; counts are frozen while it is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win       <= '0;
            y_cnt     <= '0;
            z_cnt     <= '0;
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        y_cnt <= '0;
                        z_cnt <= '0;
                        win   <= WIN_LOAD;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (y_rise && (y_cnt != CNT_MAX)) begin
                        y_cnt <= y_cnt + 1'b1;
                    end
                    if (z_rise && (z_cnt != CNT_MAX)) begin
                        z_cnt <= z_cnt + 1'b1;
                    end
                    // The final cycle's rises are still counted above.
                    if (win == '0) begin
                        rpt_valid <= 1'b1;
                        state     <= REPORT;
                    end else begin
                        win <= win - 1'b1;
                    end
                end
                REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rpt_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yz_event_counter.sv
// Randomised bench for yz_event_counter: an edge-history reference model predicts
// the window counts for an 8-bit and a 2-bit (saturating) instance.
module tb_yz_event_counter;
    import yz_mon_pkg::*;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       y = 1'b0;
    logic       z = 1'b0;
    logic       rpt_ready = 1'b0;
    logic       busy8, valid8, busy2, valid2;
    logic [7:0] ycnt8, zcnt8;
    logic [1:0] ycnt2, zcnt2;
    yz_state_t  state8, state2;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: y/z value sampled at every edge since reset (index 0 = reset value).
    logic        y_hist[$];
    logic        z_hist[$];
    int          edge_n = 0;
    int          m_phase = 0;     // 0 idle, 1 counting, 2 reporting
    int          m_e0 = -1;       // edge at which the current/last window was started
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    yz_event_counter #(.CNT_W(8), .WIN_LEN(WIN)) dut8 (
        .clk(clk), .rst(rst), .start(start), .y(y), .z(z),
        .busy(busy8), .rpt_valid(valid8), .rpt_ready(rpt_ready),
        .y_cnt(ycnt8), .z_cnt(zcnt8), .state(state8)
    );

    yz_event_counter #(.CNT_W(2), .WIN_LEN(WIN)) dut2 (
        .clk(clk), .rst(rst), .start(start), .y(y), .z(z),
        .busy(busy2), .rpt_valid(valid2), .rpt_ready(rpt_ready),
        .y_cnt(ycnt2), .z_cnt(zcnt2), .state(state2)
    );

    // Rising edges seen in the window so far, clipped to the counter range.
    function automatic int model_cnt(input int which, input int w);
        int sum;
        int last;
        int max_v;
        sum = 0;
        max_v = (1 << w) - 1;
        if (m_e0 < 0) return 0;
        last = (edge_n - 1 < m_e0 + WIN - 1) ? edge_n - 1 : m_e0 + WIN - 1;
        for (int n = m_e0; n <= last; n++) begin
            if (which == 0) sum += (y_hist[n] && !y_hist[n-1]) ? 1 : 0;
            else            sum += (z_hist[n] && !z_hist[n-1]) ? 1 : 0;
        end
        return (sum > max_v) ? max_v : sum;
    endfunction

    function automatic void model_reset();
        y_hist.delete();
        z_hist.delete();
        y_hist.push_back(1'b0);
        z_hist.push_back(1'b0);
        edge_n = 0;
        m_phase = 0;
        m_e0 = -1;
        exp_q.delete();
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input logic yv, input logic zv, input logic st, input logic rdy);
        y = yv;
        z = zv;
        start = st;
        rpt_ready = rdy;
        @(posedge clk);
        edge_n++;
        y_hist.push_back(yv);
        z_hist.push_back(zv);
        case (m_phase)
            0: if (st) begin m_phase = 1; m_e0 = edge_n; end
            1: if (edge_n == m_e0 + WIN) begin
                   m_phase = 2;
                   exp_q.push_back({8'(model_cnt(0, 8)), 8'(model_cnt(1, 8))});
               end
            default: if (rdy) m_phase = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        start = 1'b0;
        rpt_ready = 1'b0;
        y = 1'b0;
        z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        tests_run++;
        if ({busy8, valid8, ycnt8, zcnt8} !== 18'd0 || state8 !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_dut8: got busy=%b valid=%b y=%0d z=%0d st=%0d required all 0 IDLE",
                     busy8, valid8, ycnt8, zcnt8, state8);
        end
        tests_run++;
        if ({busy2, valid2, ycnt2, zcnt2} !== 6'd0 || state2 !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_dut2: got busy=%b valid=%b y=%0d z=%0d required all 0",
                     busy2, valid2, ycnt2, zcnt2);
        end
        release_reset();
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        tests_run++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || ycnt8 !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_hold: got busy=%b valid=%b y=%0d required 0 0 0", busy8, valid8, ycnt8);
        end
    endtask

    task automatic test_square_wave();
        logic yv;
        int   cyc;
        yv = 1'b0;
        for (int i = 0; i < 4; i++) begin yv = ~yv; step(yv, 1'b0, 1'b0, 1'b0); end
        yv = ~yv;
        step(yv, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin yv = ~yv; step(yv, 1'b0, 1'b0, 1'b0); cyc++; end
        tests_run++;
        if (cyc !== WIN) begin
            tests_failed++;
            $display("FAIL sq_latency: got %0d cycles required %0d", cyc, WIN);
        end
        tests_run++;
        if (ycnt8 !== 8'd8 || zcnt8 !== 8'd0) begin
            tests_failed++;
            $display("FAIL sq_counts: got y=%0d z=%0d required y=8 z=0", ycnt8, zcnt8);
        end
        tests_run++;
        if (ycnt8 !== 8'(model_cnt(0, 8)) || ycnt2 !== 2'(model_cnt(0, 2))) begin
            tests_failed++;
            $display("FAIL sq_model: got y8=%0d y2=%0d required %0d %0d",
                     ycnt8, ycnt2, model_cnt(0, 8), model_cnt(0, 2));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || state8 !== IDLE) begin
            tests_failed++;
            $display("FAIL sq_ack: got busy=%b valid=%b required 0 0", busy8, valid8);
        end
    endtask

    task automatic test_level_vs_edge();
        int cyc;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin step(1'b1, 1'b0, 1'b0, 1'b0); cyc++; end
        tests_run++;
        if (ycnt8 !== 8'd0 || zcnt8 !== 8'd0 || !valid8) begin
            tests_failed++;
            $display("FAIL level_counts: got y=%0d z=%0d valid=%b required 0 0 1", ycnt8, zcnt8, valid8);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin
            cyc++;
            step(1'b1, (cyc == 2 || cyc == 5 || cyc == 8), 1'b0, 1'b0);
        end
        tests_run++;
        if (zcnt8 !== 8'd3 || ycnt8 !== 8'd0 || zcnt2 !== 2'd3) begin
            tests_failed++;
            $display("FAIL pulse_counts: got z8=%0d y8=%0d z2=%0d required 3 0 3", zcnt8, ycnt8, zcnt2);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        logic v;
        int   cyc;
        v = 1'b0;
        for (int i = 0; i < 3; i++) begin v = ~v; step(v, v, 1'b0, 1'b0); end
        v = ~v;
        step(v, v, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin v = ~v; step(v, v, 1'b0, 1'b0); cyc++; end
        tests_run++;
        if (ycnt2 !== 2'd3 || zcnt2 !== 2'd3 || !valid2) begin
            tests_failed++;
            $display("FAIL sat_dut2: got y=%0d z=%0d valid=%b required 3 3 1", ycnt2, zcnt2, valid2);
        end
        tests_run++;
        if (ycnt8 !== 8'd8 || zcnt8 !== 8'd8) begin
            tests_failed++;
            $display("FAIL sat_dut8: got y=%0d z=%0d required 8 8", ycnt8, zcnt8);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int         cyc;
        logic [7:0] held_y, held_z;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc++;
        end
        held_y = ycnt8;
        held_z = zcnt8;
        tests_run++;
        if (held_y !== 8'(model_cnt(0, 8)) || held_z !== 8'(model_cnt(1, 8))) begin
            tests_failed++;
            $display("FAIL bp_counts: got y=%0d z=%0d required %0d %0d",
                     held_y, held_z, model_cnt(0, 8), model_cnt(1, 8));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i == 2), 1'b0);
            tests_run++;
            if (valid8 !== 1'b1 || ycnt8 !== held_y || zcnt8 !== held_z) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid=%b y=%0d z=%0d required 1 %0d %0d",
                         i, valid8, ycnt8, zcnt8, held_y, held_z);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (valid8 !== 1'b0 || busy8 !== 1'b0 || state8 !== IDLE) begin
            tests_failed++;
            $display("FAIL bp_ack: got valid=%b busy=%b required 0 0", valid8, busy8);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (busy8 !== 1'b0 || ycnt8 !== held_y || zcnt8 !== held_z) begin
            tests_failed++;
            $display("FAIL bp_no_new_window: got busy=%b y=%0d z=%0d required 0 %0d %0d",
                     busy8, ycnt8, zcnt8, held_y, held_z);
        end
    endtask

    task automatic test_reset_mid_window();
        int cyc;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'(i % 2), 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (busy8 !== 1'b1 || state8 !== COUNT) begin
            tests_failed++;
            $display("FAIL mid_busy: got busy=%b state=%0d required 1 COUNT", busy8, state8);
        end
        assert_reset();
        tests_run++;
        if (busy8 !== 1'b0 || valid8 !== 1'b0 || ycnt8 !== 8'd0 || zcnt8 !== 8'd0 || busy2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got busy=%b valid=%b y=%0d z=%0d required all 0",
                     busy8, valid8, ycnt8, zcnt8);
        end
        release_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (!valid8 && cyc < 40) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc++;
        end
        tests_run++;
        if (cyc !== WIN || ycnt8 !== 8'(model_cnt(0, 8)) || zcnt8 !== 8'(model_cnt(1, 8))) begin
            tests_failed++;
            $display("FAIL mid_fresh_window: got cyc=%0d y=%0d z=%0d required %0d %0d %0d",
                     cyc, ycnt8, zcnt8, WIN, model_cnt(0, 8), model_cnt(1, 8));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic       yv, zv, st, rdy;
        logic [15:0] exp_rpt;
        int         reports;
        exp_q.delete();
        reports = 0;
        for (int i = 0; i < 400; i++) begin
            yv  = 1'($urandom_range(0, 1));
            zv  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if (valid8 && rdy) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_report: got unexpected report y=%0d z=%0d", ycnt8, zcnt8);
                end else begin
                    exp_rpt = exp_q.pop_front();
                    reports++;
                    if ({ycnt8, zcnt8} !== exp_rpt) begin
                        tests_failed++;
                        $display("FAIL rnd_report: got y=%0d z=%0d required y=%0d z=%0d",
                                 ycnt8, zcnt8, exp_rpt[15:8], exp_rpt[7:0]);
                    end
                end
            end
            step(yv, zv, st, rdy);
            tests_run++;
            if (busy8 !== (m_phase != 0) || valid8 !== (m_phase == 2) ||
                ycnt8 !== 8'(model_cnt(0, 8)) || zcnt8 !== 8'(model_cnt(1, 8)) ||
                ycnt2 !== 2'(model_cnt(0, 2)) || zcnt2 !== 2'(model_cnt(1, 2))) begin
                tests_failed++;
                $display("FAIL rnd_cycle%0d: got busy=%b valid=%b y8=%0d z8=%0d y2=%0d z2=%0d required %b %b %0d %0d %0d %0d",
                         i, busy8, valid8, ycnt8, zcnt8, ycnt2, zcnt2, (m_phase != 0), (m_phase == 2),
                         model_cnt(0, 8), model_cnt(1, 8), model_cnt(0, 2), model_cnt(1, 2));
            end
        end
        tests_run++;
        if (reports < 3) begin
            tests_failed++;
            $display("FAIL rnd_activity: got %0d reports required at least 3", reports);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_square_wave();
        test_level_vs_edge();
        test_saturation();
        test_backpressure();
        test_reset_mid_window();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
